// File: rtl/shift_subtract_divider_pkg.sv
// Shared definitions for the multi-cycle restoring divider: default widths,
// counter width and the controller state encoding.
package shift_subtract_divider_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;
  localparam int CNT_W  = $clog2(DEF_DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_subtract_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor and keep the difference only when it does not underflow.
module shift_subtract_divider_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] i_partial_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW:0]   o_partial_rem,
  output logic          o_qbit
);

  logic [VW:0] w_trial;
  logic [VW:0] w_divisor;

  // The partial remainder is always below the divisor, so its top bit is zero
  // and only the low VW bits take part in forming the trial value.
  assign w_trial       = {i_partial_rem, i_bit};
  assign w_divisor     = {1'b0, i_divisor};
  assign o_qbit        = (w_trial >= w_divisor);
  assign o_partial_rem = o_qbit ? (w_trial - w_divisor) : w_trial;

endmodule

// File: rtl/shift_subtract_divider.sv
// Restoring divider producing one quotient bit per clock, with a
// start/busy/done handshake and a divide-by-zero flag.
module shift_subtract_divider
  import shift_subtract_divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(DW + 1);

  // Handshake: start is accepted on a rising edge whenever the controller is
  // not in CALC (IDLE or FIN); busy is high from acceptance until the result
  // edge, done pulses for exactly the one FIN cycle in which the freshly loaded
  // quotient/remainder/div_zero first appear, and starts seen while busy are dropped.
  state_t          r_state;
  logic [DW-1:0]   r_dvd;
  logic [DW-1:0]   r_quo;
  logic [VW-1:0]   r_dvs;
  logic [VW:0]     r_prem;
  logic [CW-1:0]   r_cnt;
  logic            r_zero;
  logic            r_busy;
  logic            r_done;
  logic            r_dz;
  logic [DW-1:0]   r_q_out;
  logic [VW-1:0]   r_r_out;

  logic [VW:0]     w_prem_nxt;
  logic            w_qbit;
  logic            w_accept;
  logic            w_unused;

  assign w_accept = start && (r_state != CALC);
  assign w_unused = r_prem[VW];

  shift_subtract_divider_step #(
    .VW(VW)
  ) u_divider_step (
    .i_partial_rem (r_prem[VW-1:0]),
    .i_bit         (r_dvd[DW-1]),
    .i_divisor     (r_dvs),
    .o_partial_rem (w_prem_nxt),
    .o_qbit        (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, FIN: begin
          if (w_accept) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_prem  <= '0;
            r_quo   <= '0;
            r_zero  <= (divisor == '0);
            // A zero divisor spends a single busy cycle in CALC before FIN.
            r_cnt   <= (divisor == '0) ? CW'(1) : CW'(DW);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (r_zero) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q_out <= '1;
            r_r_out <= '0;
            r_dz    <= 1'b1;
            r_state <= FIN;
          end else begin
            r_prem <= w_prem_nxt;
            r_quo  <= {r_quo[DW-2:0], w_qbit};
            r_dvd  <= {r_dvd[DW-2:0], 1'b0};
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_q_out <= {r_quo[DW-2:0], w_qbit};
              r_r_out <= w_prem_nxt[VW-1:0];
              r_dz    <= 1'b0;
              r_state <= FIN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_q_out;
  assign remainder = r_r_out;
  assign div_zero  = r_dz;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Directed bench for shift_subtract_divider: a driver pushes expected results
// (including the cycle done must appear) and a negedge monitor checks them.
module tb_shift_subtract_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {expected done cycle[31:0], div_zero, quotient[7:0], remainder[3:0]}
  logic [44:0] exp_q[$];
  logic [44:0] mon_e;
  logic [12:0] prev_out = '0;
  logic        prev_ok = 1'b0;

  shift_subtract_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", 32'(cyc), mon_e[44:13]);
        check("quotient", 32'(quotient), 32'(mon_e[11:4]));
        check("remainder", 32'(remainder), 32'(mon_e[3:0]));
        check("div_zero", 32'(div_zero), 32'(mon_e[12]));
        check("busy_at_done", 32'(busy), 32'd0);
        check("state_at_done", 32'(dbg_state), 32'd2);
      end
    end else if (rst_n && prev_ok) begin
      check("outputs_stable", 32'({div_zero, quotient, remainder}), 32'(prev_out));
    end
    prev_out = {div_zero, quotient, remainder};
    prev_ok  = rst_n;
  end

  // ---------------- driver tasks ----------------
  // Caller must be at a negedge; start is held across exactly one rising edge.
  task automatic issue(input logic [7:0] dd, input logic [3:0] dv,
                       input logic [7:0] eq, input logic [3:0] er, input logic ez);
    int lat;
    lat = (dv == 4'd0) ? 1 : DW;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    exp_q.push_back({32'(cyc + 1 + lat), ez, eq, er});
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom_range(0, 255));
    divisor  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d results pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_done_edge();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got done=0 expected done within 20 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    int b;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 120/10: busy for 8 cycles, done on the 9th
    @(negedge clk);
    issue(8'd120, 4'd10, 8'd12, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_during_calc", 32'(busy), 32'd1);
    end
    wait_idle();

    // 200/7 then 255/15 accepted in the FIN cycle of the first
    @(negedge clk);
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    wait_done_edge();
    issue(8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_idle();

    // 5/9, then divide by zero
    @(negedge clk);
    issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    wait_idle();
    @(negedge clk);
    issue(8'd77, 4'd0, 8'hFF, 4'd0, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);
    check("div_zero_held", 32'(div_zero), 32'd1);

    // multiplier products fed back through the divider
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin a = 10; b = 12; end
        1: begin a = 14; b = 15; end
        2: begin a = 9;  b = 9;  end
        default: begin a = 17; b = 15; end
      endcase
      @(negedge clk);
      issue(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0);
      wait_idle();
    end

    // 100/3 with starts at cycles 2 and 5 that must be ignored
    @(negedge clk);
    issue(8'd100, 4'd3, 8'd33, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd250; divisor = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored", 32'(busy), 32'd1);
    wait_idle();

    // reset in the middle of a run
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", 32'(quotient), 32'd0);
    @(negedge clk);
    issue(8'd120, 4'd10, 8'd12, 4'd0, 1'b0);
    wait_idle();

    // round-trip sweep over every nonzero divisor
    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        @(negedge clk);
        issue(8'(dd), 4'(dv), 8'(dd / dv), 4'(dd % dv), 1'b0);
        wait_idle();
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_subtract_divider.md
Name: shift_subtract_divider

Overview:
- Multi-cycle restoring divider; the inverse of the team's combinational multiplier.
- Takes an 8-bit dividend (product width) and a 4-bit divisor, and returns quotient and remainder, one quotient bit per clock.
- Uses a start/busy/done handshake so a testbench or controller can drive it beside the multiplier and check that multiply and divide round-trip.

Parameters:
- DW, 8, dividend and quotient width (number of iterations).
- VW, 4, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse, sampled on rising clk.
- dividend  input  DW  numerator, captured when start is accepted.
- divisor  input  VW  denominator, captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  DW  result, held until the next accepted start.
- remainder  output  VW  result, held until the next accepted start.
- div_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, div_zero=0.
  - quotient=0, remainder=0.
  - Internal counter and working registers=0.
- States: IDLE, CALC, FIN.
- IDLE or FIN with start=1 accepts the request:
  - Latch dividend and divisor.
  - Clear partial remainder (VW+1 bits) and quotient shift register.
  - cnt=DW, clear div_zero.
  - If divisor==0, go to FIN next cycle. Otherwise go to CALC.
- CALC, each cycle:
  - Form trial = {partial_rem[VW-1:0], dividend_msb}, VW+1 bits.
  - If trial >= {1'b0, divisor}: partial_rem = trial - divisor, and shift 1 into the quotient LSB.
  - Else: partial_rem = trial, and shift 0 into the quotient LSB.
  - Shift the dividend left by 1 and decrement cnt.
  - After the cycle in which cnt goes 1->0, go to FIN.
- FIN, lasts exactly one cycle:
  - done=1.
  - quotient and remainder outputs load from the working registers (remainder = partial_rem[VW-1:0]).
  - Next state is IDLE, or back to CALC/FIN if start is accepted this same cycle.
- busy=1 in CALC and in the zero-divisor cycle leading to FIN; busy=0 in IDLE and FIN.
- Latency:
  - start accepted at edge N gives done high during the cycle after edge N+DW (DW+1 cycles, i.e. 9 by default).
  - Divide-by-zero gives done one cycle after acceptance.
- Divide-by-zero result: quotient all ones, remainder=0, div_zero=1; div_zero is held with the results.
- start while busy: ignored; the operation in flight is unaffected.
- Input changes after acceptance have no effect.
- Outputs change only in FIN or on reset; between results they are stable.
- Reset mid-operation aborts immediately: everything returns to reset values and no done pulse is produced.
- Arithmetic is unsigned; the invariant dividend == quotient*divisor + remainder, with remainder < divisor, must hold whenever divisor != 0.

Decomposition:
- Shared package:
  - State enum/localparams: IDLE=2'd0, CALC=2'd1, FIN=2'd2.
  - Default widths DW=8, VW=4.
  - Counter width constant $clog2(DW+1).
- One natural sub-module, divider_step: combinational single iteration.
  - In: partial_rem, next dividend bit, divisor.
  - Out: new partial_rem, quotient bit.
  - Instantiated once inside the FSM datapath.

Test Plan:
- 120/10, start pulse:
  - busy high 8 cycles; done at cycle 9.
  - quotient=12, remainder=0, div_zero=0.
- 200/7 -> quotient=28, remainder=4. Then 255/15 back-to-back (start during FIN) -> quotient=17, remainder=0, with no idle gap.
- 5/9 -> quotient=0, remainder=5. Then divisor 0 with dividend 77 -> done after 1 cycle, div_zero=1, quotient=8'hFF, remainder=0.
- Round-trip sweep: for all dividends 0..255 and divisors 1..15, check quotient*divisor+remainder==dividend and remainder<divisor. Also feed each multiplier product back (e.g. 10*12=120 /12 -> 10, remainder 0).
- start pulses with changing inputs at cycles 2 and 5 of a 100/3 run -> ignored; result quotient=33, remainder=1.
- rst_n low at cycle 4 of a run -> all outputs 0 asynchronously; no done pulse; a fresh start afterwards completes normally.
